// File: rtl/common.sv
// Shared CBus / AXI type definitions used by the CBus arbiter and its neighbours.
//   axi_burst_type_t : AXI burst encoding (FIXED, INCR, WRAP)
//   axi_burst_size_t : AXI beat size encoding (bytes per beat = 2**size)
//   axi_burst_len_t  : AXI burst length (beats - 1)
//   cbus_req_t       : request from a CBus master (valid, write flag, size, addr,
//                      strobe, write data, len, burst)
//   cbus_resp_t      : response from a CBus slave (ready, last, read data)
package common;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10
   } axi_burst_type_t;

   typedef enum logic [2:0] {
      MSIZE1   = 3'b000,
      MSIZE2   = 3'b001,
      MSIZE4   = 3'b010,
      MSIZE8   = 3'b011,
      MSIZE16  = 3'b100,
      MSIZE32  = 3'b101,
      MSIZE64  = 3'b110,
      MSIZE128 = 3'b111
   } axi_burst_size_t;

   typedef logic [7:0] axi_burst_len_t;

   typedef struct packed {
      logic            valid;
      logic            is_write;
      axi_burst_size_t size;
      logic [63:0]     addr;
      logic [7:0]      strobe;
      logic [63:0]     data;
      axi_burst_len_t  len;
      axi_burst_type_t burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one downstream CBus slave (the SRAM bridge) between
// NUM_REQ upstream masters (index 0 = instruction side, 1 = data side).
//
// Ports
//   clk     in   clock, all state changes on posedge
//   reset   in   synchronous, active-high reset
//   ireqs   in   cbus_req_t  [NUM_REQ] upstream requests
//   oresps  out  cbus_resp_t [NUM_REQ] upstream responses
//   oreq    out  cbus_req_t  request forwarded to the downstream slave
//   oresp   in   cbus_resp_t response from the downstream slave
//
// Operation: IDLE picks an owner (one arbitration cycle, nothing forwarded),
// BUSY connects the owner to the slave combinationally until its last beat
// completes or it withdraws its request. Bursts are passed through untouched.
//
// Build option: define CBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest
// valid index wins, rr_ptr pinned to 0); default is round-robin.
module cbus_arbiter
   import common::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireqs  [NUM_REQ],
   output cbus_resp_t oresps [NUM_REQ],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam int OW = $clog2(NUM_REQ);
   typedef logic [OW-1:0] idx_t;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_q, state_d;
   idx_t        owner_q, owner_d;
   idx_t        rr_ptr_q, rr_ptr_d;
   logic [31:0] busy_cycles_q, busy_cycles_d;   // simulation statistic only

   idx_t        grant_idx;
   logic        grant_vld;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   function automatic idx_t next_idx(input idx_t i);
      return (i == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(i + idx_t'(1));
   endfunction

   // Requester selection: first valid index starting from the search origin.
   always_comb begin
      int cand;
      cand      = 0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CBUS_ARB_FIXED_PRIO_EN
         cand = k;
`else
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
         if (!grant_vld && ireqs[idx_t'(cand)].valid) begin
            grant_vld = 1'b1;
            grant_idx = idx_t'(cand);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      busy_cycles_d = busy_cycles_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_d = BUSY;
               owner_d = grant_idx;
            end
         end
         BUSY: begin
            busy_cycles_d = sat_inc(busy_cycles_q);
            if (!ireqs[owner_q].valid) begin
               // Owner withdrew mid-transfer: release without moving the pointer.
               state_d = IDLE;
            end else if (oresp.ready && oresp.last) begin
               // No same-cycle regrant; the next owner is chosen from IDLE.
               state_d = IDLE;
`ifdef CBUS_ARB_FIXED_PRIO_EN
               rr_ptr_d = '0;
`else
               rr_ptr_d = next_idx(owner_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus routing; gated by reset so nothing leaks while reset is held.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_REQ; i++) oresps[i] = '0;
      if (state_q == BUSY && !reset) begin
         oreq            = ireqs[owner_q];
         oresps[owner_q] = oresp;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         busy_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         busy_cycles_q <= busy_cycles_d;
      end
   end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The module SHALL import common::* and use its cbus_req_t, cbus_resp_t, AXI burst and size definitions unchanged.
REQ-002 Parameter NUM_REQ, default 2, SHALL give the number of upstream requesters; legal range 2..8.
REQ-003 Ports SHALL be exactly:
- clk  input  1  clock; all state changes on posedge clk.
- reset  input  1  reset, synchronous, active-high.
- ireqs  input  cbus_req_t[NUM_REQ]  upstream requests; index 0 = instruction side, 1 = data side.
- oresps  output  cbus_resp_t[NUM_REQ]  upstream responses.
- oreq  output  cbus_req_t  request to the single downstream CBus slave (the SRAM bridge).
- oresp  input  cbus_resp_t  response from the downstream slave.

Function
REQ-004 The arbiter SHALL have two states: IDLE (no owner) and BUSY (one owner holds the bus).
REQ-005 IDLE: if any ireqs[i].valid is high, the arbiter SHALL select one requester, register it as owner (index width $clog2(NUM_REQ)), and enter BUSY on the next edge; otherwise it SHALL stay in IDLE.
REQ-006 Selection SHALL be round-robin: search starts at index rr_ptr, wraps from NUM_REQ-1 to 0, and picks the first valid requester.
REQ-007 In IDLE, oreq SHALL be all-zero (valid=0) and every oresps[i] SHALL be all-zero; arbitration therefore costs exactly one cycle before the owner's request reaches the slave.
REQ-008 BUSY: oreq SHALL equal ireqs[owner] combinationally, oresps[owner] SHALL equal oresp combinationally, and every non-owner oresps[j] SHALL be all-zero.
REQ-009 BUSY SHALL end when oresp.ready && oresp.last is high and ireqs[owner].valid is high; the arbiter SHALL then return to IDLE and set rr_ptr to (owner+1) mod NUM_REQ on that edge.
REQ-010 A new grant SHALL NOT be issued in the cycle the last beat completes; the next transaction is granted from IDLE one cycle later, giving one dead cycle between transactions.
REQ-011 If ireqs[owner].valid drops while BUSY without a completed last beat, the arbiter SHALL return to IDLE without advancing rr_ptr.
REQ-012 Requests from non-owners SHALL be held off, with their oresps ready=0, for as long as they stay valid; none SHALL be lost or reordered.
REQ-013 A 32-bit saturating counter busy_cycles SHALL increment every cycle in BUSY; it is for simulation only and drives no port.
REQ-014 FIXED and INCR bursts SHALL pass through unmodified; the arbiter SHALL NOT inspect len, size or addr.

Reset
REQ-015 While reset is high, the state SHALL be IDLE, owner 0, rr_ptr 0, busy_cycles 0, oreq all-zero and all oresps all-zero.
REQ-016 Reset asserted mid-BUSY SHALL abandon the transfer immediately; the first grant after reset SHALL be decided from rr_ptr=0.

Configuration
REQ-017 Macro CBUS_ARB_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority (lowest valid index wins) and rr_ptr SHALL stay at 0.
REQ-018 When CBUS_ARB_FIXED_PRIO_EN is undefined, selection SHALL be round-robin as in REQ-006.

Verification
REQ-019 Single requester: ireqs[1] issues an INCR read with len=3; one-cycle delay -> oreq mirrors ireqs[1], oresps[1] sees 4 beats with last on the 4th, oresps[0] stays zero, and the arbiter returns to IDLE.
REQ-020 Simultaneous requests after reset: ireqs[0] and ireqs[1] both valid, FIXED bursts -> requester 0 is served first, then after one dead cycle requester 1.
REQ-021 Fairness: both requesters are continuously valid for 6 transactions -> owner sequence is 0,1,0,1,0,1; with CBUS_ARB_FIXED_PRIO_EN defined -> 0,0,0,0,0,0.
REQ-022 Reset mid-burst: reset is pulsed during beat 2 of an INCR len=7 -> next cycle the state is IDLE, oreq.valid=0, and all oresps are zero.
REQ-023 Write then read: ireqs[1] issues a write (strobe=8'hFF, data=64'h1234), then ireqs[0] issues a read of the same address -> oresps[0].data=64'h1234.
REQ-024 Wrap-around with NUM_REQ=3: rr_ptr=2 and requesters 0 and 1 are valid -> requester 0 is granted.
